// File: rtl/tt_sel_driver_pkg.sv
// ---------------------------------------------------------------------------
// tt_sel_driver_pkg
//   Shared definitions for the design-select pin driver:
//     - sel_state_t : FSM state encoding, also used by formal property files
//     - phase_w()   : width of the per-phase down counter for a given HALF
//   No ports (package).
// ---------------------------------------------------------------------------
package tt_sel_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,  // waiting for a request, ena holds its last value
        ST_RST    = 3'd1,  // select counter held in reset
        ST_SETTLE = 3'd2,  // reset released, counter settles before pulsing
        ST_INC_H  = 3'd3,  // increment pin high phase
        ST_INC_L  = 3'd4,  // increment pin low phase, one pulse ends here
        ST_ENA    = 3'd5   // selection complete, enable asserted
    } sel_state_t;

    // Phase timer width; a HALF below 1 is treated as 1 so the width
    // never collapses to zero.
    function automatic int phase_w(input int half);
        return (half < 1) ? 1 : $clog2(half + 1);
    endfunction

endpackage

// File: rtl/tt_phase_timer.sv
// ---------------------------------------------------------------------------
// tt_phase_timer
//   Down counter that measures one pulse phase of HALF cycles. Pulsing
//   load restarts the phase; expire is high during the last cycle of it.
//   Ports:
//     clk     in  system clock
//     rst_n   in  synchronous active-low reset
//     load    in  restart the phase (asserted on every FSM state entry)
//     expire  out current cycle is the final cycle of the phase
// ---------------------------------------------------------------------------
module tt_phase_timer #(
    parameter int HALF = 2,
    parameter int W    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    // Loading HALF-1 makes the phase that starts after the load edge last
    // exactly HALF cycles, with expire on the last one.
    localparam logic [W-1:0] RELOAD = W'((HALF < 1) ? 0 : HALF - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state is only ever written with non-blocking
    // assignments so every flop samples pre-edge values, independent of
    // block ordering in simulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/tt_sel_driver.sv
// ---------------------------------------------------------------------------
// tt_sel_driver
//   Drives the mux control pins feeding tt_top's design-select controller.
//   For an accepted address it pulses the select counter reset, waits for it
//   to settle, emits exactly addr increment pulses and then raises ena.
//   Every output is a flop, decoded from the next state, so the pins never
//   glitch.
//   Ports:
//     clk             in   system clock
//     rst_n           in   synchronous active-low reset
//     req_valid       in   select request present
//     req_ready       out  driver idle, can accept a request
//     req_addr        in   target design address, sampled on accept
//     dis             in   drop ena (deselect) while idle
//     done            out  1-cycle pulse: selection complete, ena now high
//     err             out  1-cycle pulse: request rejected (addr >= N_PROJ)
//     busy            out  sequence in progress
//     ctrl_sel_rst_n  out  to tt_top select-counter reset, active-low
//     ctrl_sel_inc    out  to tt_top select-counter increment
//     ctrl_ena        out  to tt_top enable of the selected design
// ---------------------------------------------------------------------------
module tt_sel_driver
    import tt_sel_driver_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int N_PROJ = 384,
    parameter int HALF   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              dis,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    localparam int PW = phase_w(HALF);

    // One extra bit so N_PROJ == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] N_PROJ_L = (ADDR_W + 1)'(N_PROJ);

    sel_state_t        state;
    sel_state_t        next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] cnt_inc;
    logic              ena_d;
    logic              err_d;
    logic              accept;
    logic              addr_bad;
    logic              phase_load;
    logic              phase_expire;

    tt_phase_timer #(
        .HALF (HALF),
        .W    (PW)
    ) u_phase_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (phase_load),
        .expire (phase_expire)
    );

    // req_ready is itself a flop that is high only in IDLE, so it doubles
    // as the accept qualifier and requests while busy are simply dropped.
    assign accept     = req_valid & req_ready;
    assign addr_bad   = ({1'b0, req_addr} >= N_PROJ_L);
    assign cnt_inc    = cnt_q + ADDR_W'(1);
    // Every state change starts a fresh phase.
    assign phase_load = (next_state != state);

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        ena_d      = ctrl_ena;
        err_d      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    // Accept takes priority over a simultaneous dis.
                    if (addr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d     = req_addr;
                        cnt_d      = '0;
                        ena_d      = 1'b0;
                        next_state = ST_RST;
                    end
                end else if (dis) begin
                    ena_d = 1'b0;
                end
            end
            ST_RST: begin
                if (phase_expire) next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (phase_expire) next_state = (addr_q == '0) ? ST_ENA : ST_INC_H;
            end
            ST_INC_H: begin
                if (phase_expire) next_state = ST_INC_L;
            end
            ST_INC_L: begin
                // The pulse is counted as its low phase ends.
                if (phase_expire) begin
                    cnt_d      = cnt_inc;
                    next_state = (cnt_inc == addr_q) ? ST_ENA : ST_INC_H;
                end
            end
            ST_ENA: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // ena rises together with the done pulse and then holds.
        if (next_state == ST_ENA) ena_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            cnt_q          <= '0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            req_ready      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= next_state;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            // Decoding from next_state makes each pin change on the same
            // edge as the state it belongs to; inc is only high in INC_H,
            // so it can never overlap the counter reset.
            ctrl_sel_rst_n <= (next_state != ST_RST);
            ctrl_sel_inc   <= (next_state == ST_INC_H);
            ctrl_ena       <= ena_d;
            done           <= (next_state == ST_ENA);
            err            <= err_d;
            req_ready      <= (next_state == ST_IDLE);
            busy           <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_tt_sel_driver.sv
// ---------------------------------------------------------------------------
// tb_tt_sel_driver
//   Self-checking bench for tt_sel_driver. Expected pin activity is derived
//   from the selection rules: HALF cycles of counter reset, addr increment
//   edges, done 2*HALF*(1+addr)+1 cycles after accept, err one cycle after a
//   rejected request, and a tracked expected value for ctrl_ena.
// ---------------------------------------------------------------------------
module tb_tt_sel_driver;

    localparam int ADDR_W = 10;
    localparam int N_PROJ = 384;
    localparam int HALF   = 2;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              dis;
    logic              done;
    logic              err;
    logic              busy;
    logic              ctrl_sel_rst_n;
    logic              ctrl_sel_inc;
    logic              ctrl_ena;

    int n_vec;
    int n_bad;
    bit ena_exp;

    tt_sel_driver #(
        .ADDR_W (ADDR_W),
        .N_PROJ (N_PROJ),
        .HALF   (HALF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .dis            (dis),
        .done           (done),
        .err            (err),
        .busy           (busy),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Full selection of address a. with_dis raises dis in the accept cycle;
    // noisy drives random req/dis traffic while the sequence runs.
    task automatic run_select(input int a, input bit with_dis, input bit noisy);
        int exp_lat;
        int done_off;
        int edges;
        int rst_low;
        int viol;
        bit prev_inc;
        exp_lat  = 2 * HALF * (1 + a) + 1;
        done_off = 0;
        edges    = 0;
        rst_low  = 0;
        viol     = 0;
        prev_inc = 1'b0;

        @(negedge clk);
        check("ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(a);
        dis       = with_dis;
        @(posedge clk);

        for (int off = 1; off <= exp_lat + 20 && done_off == 0; off++) begin
            @(negedge clk);
            if (!ctrl_sel_rst_n) rst_low++;
            if (ctrl_sel_inc && !prev_inc) edges++;
            prev_inc = ctrl_sel_inc;
            if (ctrl_sel_inc && !ctrl_sel_rst_n) viol++;
            if (done && err) viol++;
            if (done) done_off = off;
            else if (req_ready || !busy || ctrl_ena || err) viol++;
            if (done || !noisy) begin
                req_valid = 1'b0;
                dis       = 1'b0;
            end else begin
                req_valid = 1'($urandom_range(0, 1));
                req_addr  = ADDR_W'($urandom);
                dis       = 1'($urandom_range(0, 1));
            end
        end

        check($sformatf("done_lat a=%0d", a), done_off, exp_lat);
        check($sformatf("inc_edges a=%0d", a), edges, a);
        check($sformatf("rst_cycles a=%0d", a), rst_low, HALF);
        check($sformatf("invariants a=%0d", a), viol, 0);
        check($sformatf("ena_at_done a=%0d", a), ctrl_ena, 1);
        ena_exp = 1'b1;
        @(negedge clk);
        check($sformatf("idle_after a=%0d", a), {done, req_ready, ctrl_ena, busy}, 4'b0110);
    endtask

    // Out-of-range request: err next cycle, no pin activity, ena untouched.
    task automatic run_bad(input int a);
        int act;
        act = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(a);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check($sformatf("err_pulse a=%0d", a), {err, done, req_ready}, 3'b101);
        check($sformatf("err_ena a=%0d", a), ctrl_ena, ena_exp);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!ctrl_sel_rst_n || ctrl_sel_inc || done || err || busy || ctrl_ena != ena_exp) act++;
        end
        check($sformatf("err_quiet a=%0d", a), act, 0);
    endtask

    task automatic run_dis();
        @(negedge clk);
        dis = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dis     = 1'b0;
        ena_exp = 1'b0;
        check("dis_ena", ctrl_ena, ena_exp);
    endtask

    // Reset asserted while the first increment pulse is high.
    task automatic run_midreset();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(5);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = ctrl_sel_inc;
        end
        check("mid_inc_seen", seen, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_vals",
              {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, err, req_ready, busy}, 7'b0);
        rst_n   = 1'b1;
        ena_exp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_release", {req_ready, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena}, 4'b1100);
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        ena_exp   = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        dis       = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_vals",
              {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, err, req_ready, busy}, 7'b0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_idle", {req_ready, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena}, 4'b1100);

        run_select(0, 1'b0, 1'b0);
        run_select(3, 1'b0, 1'b0);
        run_bad(N_PROJ);
        run_dis();
        run_bad(1023);
        run_select(N_PROJ - 1, 1'b0, 1'b1);
        run_midreset();
        run_select(2, 1'b0, 1'b0);
        run_select(4, 1'b1, 1'b0);

        for (int it = 0; it < 25; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      run_bad(int'($urandom_range(N_PROJ, 1023)));
            else if (r == 1) run_dis();
            else             run_select(int'($urandom_range(0, 15)),
                                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
